voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 262 ++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: eight-voice MIDI note allocator with per-voice
// attack/sustain/release envelopes, velocity-scaled volume and Q22.10 pitch.
// Build option: define VOICE_STEAL_EN so that a note-on arriving while every
// voice is busy takes over the least recently allocated voice; without it
// such a note-on is accepted and dropped.

module voice_allocator #(
   parameter int          ENV_DIV      = 48000,
   parameter logic [15:0] ATTACK_STEP  = 16'd2048,
   parameter logic [15:0] RELEASE_STEP = 16'd512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic        ev_note_on,
   input  logic [6:0]  ev_note,
   input  logic [6:0]  ev_velocity,
   output logic [31:0] frequencies   [8],
   output logic [31:0] voice_volumes [8],
   output logic [7:0]  voice_active
);

   localparam int                 PRESC_W    = $clog2(ENV_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(ENV_DIV - 1);
   localparam logic [31:0]        RESET_FREQ = 32'd450560;

   typedef enum logic [1:0] {E_IDLE, E_SEARCH, E_APPLY} ev_state_t;
   typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} voice_state_t;

   ev_state_t          ev_state;
   logic               ev_on_q;
   logic [6:0]         ev_note_q;
   logic [6:0]         ev_vel_q;
   logic               is_on_q;
   logic [31:0]        freq_q;

   voice_state_t       v_state [8];
   logic [15:0]        v_level [8];
   logic [6:0]         v_vel   [8];
   logic [6:0]         v_note  [8];
   logic [31:0]        v_freq  [8];
   logic [2:0]         v_rank  [8];

   logic [PRESC_W-1:0] presc;
   logic               tick;

   logic               found_hit;
   logic [2:0]         hit_idx;
   logic               found_idle;
   logic [2:0]         idle_idx;
`ifdef VOICE_STEAL_EN
   logic [2:0]         steal_idx;
`endif
   logic [7:0]         apply_mask;
   logic               rank_touch;
   logic               clear_level;
   logic [2:0]         target;
   logic [16:0]        att_sum  [8];
   logic [31:0]        vol_full [8];

   // Q22.10 pitch of MIDI notes 0..11; higher octaves are left shifts of these
   function automatic logic [31:0] base_freq(input logic [3:0] k);
      case (k)
         4'd0:    base_freq = 32'd8372;
         4'd1:    base_freq = 32'd8870;
         4'd2:    base_freq = 32'd9397;
         4'd3:    base_freq = 32'd9956;
         4'd4:    base_freq = 32'd10548;
         4'd5:    base_freq = 32'd11175;
         4'd6:    base_freq = 32'd11840;
         4'd7:    base_freq = 32'd12544;
         4'd8:    base_freq = 32'd13290;
         4'd9:    base_freq = 32'd14080;
         4'd10:   base_freq = 32'd14917;
         default: base_freq = 32'd15804;
      endcase
   endfunction

   assign tick = (presc == PRESC_LAST);

   // Envelope prescaler: free-running count that wraps every ENV_DIV clocks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Event FSM: capture on acceptance, normalise and look up pitch, then apply
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ev_state  <= E_IDLE;
         ev_ready  <= 1'b0;
         ev_on_q   <= 1'b0;
         ev_note_q <= '0;
         ev_vel_q  <= '0;
         is_on_q   <= 1'b0;
         freq_q    <= RESET_FREQ;
      end else begin
         case (ev_state)
            E_IDLE: begin
               ev_ready <= 1'b1;
               if (ev_valid && ev_ready) begin
                  ev_on_q   <= ev_note_on;
                  ev_note_q <= ev_note;
                  ev_vel_q  <= ev_velocity;
                  ev_ready  <= 1'b0;
                  ev_state  <= E_SEARCH;
               end
            end
            E_SEARCH: begin
               is_on_q  <= ev_on_q && (ev_vel_q != 7'd0);
               freq_q   <= base_freq(4'(ev_note_q % 7'd12)) << (ev_note_q / 7'd12);
               ev_state <= E_APPLY;
            end
            E_APPLY: begin
               ev_ready <= 1'b1;
               ev_state <= E_IDLE;
            end
            default: begin
               ev_ready <= 1'b0;
               ev_state <= E_IDLE;
            end
         endcase
      end
   end

   // Decide which voices the pending event rewrites, using the current voice states
   always_comb begin
      found_hit   = 1'b0;
      hit_idx     = '0;
      found_idle  = 1'b0;
      idle_idx    = '0;
      apply_mask  = '0;
      rank_touch  = 1'b0;
      clear_level = 1'b0;
      target      = '0;
      for (int v = 7; v >= 0; v--) begin
         if (v_state[v] != V_IDLE && v_note[v] == ev_note_q) begin
            found_hit = 1'b1;
            hit_idx   = 3'(v);
         end
         if (v_state[v] == V_IDLE) begin
            found_idle = 1'b1;
            idle_idx   = 3'(v);
         end
      end
`ifdef VOICE_STEAL_EN
      steal_idx = '0;
      for (int v = 0; v < 8; v++) begin
         if (v_rank[v] == 3'd0) begin
            steal_idx = 3'(v);
         end
      end
`endif
      if (ev_state == E_APPLY) begin
         if (!is_on_q) begin
            for (int v = 0; v < 8; v++) begin
               apply_mask[v] = (v_state[v] == V_ATTACK || v_state[v] == V_SUSTAIN) &&
                               (v_note[v] == ev_note_q);
            end
         end else if (found_hit) begin
            target              = hit_idx;
            apply_mask[hit_idx] = 1'b1;
            rank_touch          = 1'b1;
         end else if (found_idle) begin
            target               = idle_idx;
            apply_mask[idle_idx] = 1'b1;
            rank_touch           = 1'b1;
            clear_level          = 1'b1;
         end
`ifdef VOICE_STEAL_EN
         else begin
            target                = steal_idx;
            apply_mask[steal_idx] = 1'b1;
            rank_touch            = 1'b1;
            clear_level           = 1'b1;
         end
`endif
      end
   end

   // Attack increment with a carry bit so saturation at full scale is easy to detect
   always_comb begin
      for (int v = 0; v < 8; v++) begin
         att_sum[v] = {1'b0, v_level[v]} + {1'b0, ATTACK_STEP};
      end
   end

   // Voice state: an event write takes priority over the envelope tick for that voice
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < 8; v++) begin
            v_state[v] <= V_IDLE;
            v_level[v] <= '0;
            v_vel[v]   <= '0;
            v_note[v]  <= '0;
            v_freq[v]  <= RESET_FREQ;
            v_rank[v]  <= 3'(v);
         end
      end else begin
         for (int v = 0; v < 8; v++) begin
            if (apply_mask[v]) begin
               if (is_on_q) begin
                  v_state[v] <= V_ATTACK;
                  v_vel[v]   <= ev_vel_q;
                  v_note[v]  <= ev_note_q;
                  v_freq[v]  <= freq_q;
                  if (clear_level) begin
                     v_level[v] <= '0;
                  end
               end else begin
                  v_state[v] <= V_RELEASE;
               end
            end else if (tick) begin
               case (v_state[v])
                  V_ATTACK: begin
                     if (att_sum[v][16] || att_sum[v][15:0] == 16'hFFFF) begin
                        v_level[v] <= 16'hFFFF;
                        v_state[v] <= V_SUSTAIN;
                     end else begin
                        v_level[v] <= att_sum[v][15:0];
                     end
                  end
                  V_RELEASE: begin
                     if (v_level[v] <= RELEASE_STEP) begin
                        v_level[v] <= '0;
                        v_state[v] <= V_IDLE;
                     end else begin
                        v_level[v] <= v_level[v] - RELEASE_STEP;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            if (rank_touch) begin
               if (3'(v) == target) begin
                  v_rank[v] <= 3'd7;
               end else if (v_rank[v] > v_rank[target]) begin
                  v_rank[v] <= v_rank[v] - 3'd1;
               end
            end
         end
      end
   end

   // Output view: volume is level scaled by velocity/128, active means not idle
   always_comb begin
      for (int v = 0; v < 8; v++) begin
         vol_full[v]      = 32'(v_level[v]) * 32'(v_vel[v]);
         voice_volumes[v] = vol_full[v] >> 7;
         frequencies[v]   = v_freq[v];
         voice_active[v]  = (v_state[v] != V_IDLE);
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and randomized stimulus for voice_allocator,
// compared every cycle against a behavioural voice/envelope model.

module tb_voice_allocator;

   localparam int          ENV_DIV      = 4;
   localparam logic [15:0] ATTACK_STEP  = 16'd16384;
   localparam logic [15:0] RELEASE_STEP = 16'd65535;

   logic        clk         = 1'b0;
   logic        reset_n     = 1'b0;
   logic        ev_valid    = 1'b0;
   logic        ev_ready;
   logic        ev_note_on  = 1'b0;
   logic [6:0]  ev_note     = '0;
   logic [6:0]  ev_velocity = '0;
   logic [31:0] frequencies   [8];
   logic [31:0] voice_volumes [8];
   logic [7:0]  voice_active;

   int errors = 0;
   int checks = 0;

   voice_allocator #(
      .ENV_DIV      (ENV_DIV),
      .ATTACK_STEP  (ATTACK_STEP),
      .RELEASE_STEP (RELEASE_STEP)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_note_on    (ev_note_on),
      .ev_note       (ev_note),
      .ev_velocity   (ev_velocity),
      .frequencies   (frequencies),
      .voice_volumes (voice_volumes),
      .voice_active  (voice_active)
   );

   always #5 clk = ~clk;

   // Model state: 0 idle, 1 attack, 2 sustain, 3 release
   int          m_state [8];
   int          m_level [8];
   int          m_vel   [8];
   int          m_note  [8];
   int unsigned m_freq  [8];
   int          lru [$];
   int          edges;
   int          stage;
   bit          m_ready;
   bit          p_on;
   int          p_note;
   int          p_vel;
   int unsigned base_tab [12];

   function automatic int unsigned note_freq(int n);
      return base_tab[n % 12] << (n / 12);
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      lru.delete();
      for (int v = 0; v < 8; v++) begin
         m_state[v] = 0;
         m_level[v] = 0;
         m_vel[v]   = 0;
         m_note[v]  = 0;
         m_freq[v]  = 32'd450560;
         lru.push_back(v);
      end
      edges   = 0;
      stage   = 0;
      m_ready = 1'b0;
   endtask

   task automatic lru_touch(int v);
      for (int i = 0; i < lru.size(); i++) begin
         if (lru[i] == v) begin
            lru.delete(i);
            break;
         end
      end
      lru.push_back(v);
   endtask

   task automatic model_step(bit in_valid, bit in_on, int in_note, int in_vel);
      int ps [8];
      int pl [8];
      bit tick;
      bit on;
      bit acc;
      int t;
      acc = in_valid && m_ready;
      edges++;
      tick = (edges % ENV_DIV) == 0;
      for (int v = 0; v < 8; v++) begin
         ps[v] = m_state[v];
         pl[v] = m_level[v];
      end
      if (tick) begin
         for (int v = 0; v < 8; v++) begin
            if (ps[v] == 1) begin
               m_level[v] = (pl[v] + int'(ATTACK_STEP) > 65535) ? 65535 : pl[v] + int'(ATTACK_STEP);
               if (m_level[v] == 65535) m_state[v] = 2;
            end else if (ps[v] == 3) begin
               m_level[v] = (pl[v] > int'(RELEASE_STEP)) ? pl[v] - int'(RELEASE_STEP) : 0;
               if (m_level[v] == 0) m_state[v] = 0;
            end
         end
      end
      if (stage == 2) begin
         on = p_on && (p_vel != 0);
         if (!on) begin
            for (int v = 0; v < 8; v++) begin
               if ((ps[v] == 1 || ps[v] == 2) && m_note[v] == p_note) begin
                  m_state[v] = 3;
                  m_level[v] = pl[v];
               end
            end
         end else begin
            t = -1;
            for (int v = 7; v >= 0; v--) begin
               if (ps[v] != 0 && m_note[v] == p_note) t = v;
            end
            if (t >= 0) begin
               m_state[t] = 1;
               m_level[t] = pl[t];
            end else begin
               for (int v = 7; v >= 0; v--) begin
                  if (ps[v] == 0) t = v;
               end
`ifdef VOICE_STEAL_EN
               if (t < 0) t = lru[0];
`endif
               if (t >= 0) begin
                  m_state[t] = 1;
                  m_level[t] = 0;
               end
            end
            if (t >= 0) begin
               m_vel[t]  = p_vel;
               m_note[t] = p_note;
               m_freq[t] = note_freq(p_note);
               lru_touch(t);
            end
         end
      end
      if (stage == 2) stage = 0;
      else if (stage == 1) stage = 2;
      if (acc) begin
         p_on   = in_on;
         p_note = in_note;
         p_vel  = in_vel;
         stage  = 1;
      end
      m_ready = (stage == 0);
   endtask

   // Advance the model on every clock edge, reset it asynchronously
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step(ev_valid, ev_note_on, int'(ev_note), int'(ev_velocity));
   end

   // Compare all outputs against the model on every falling edge
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         begin
            logic [7:0] exp_act;
            int bad_f;
            int bad_v;
            bad_f = -1;
            bad_v = -1;
            for (int v = 7; v >= 0; v--) begin
               exp_act[v] = (m_state[v] != 0);
               if (frequencies[v] !== m_freq[v]) bad_f = v;
               if (voice_volumes[v] !== 32'((m_level[v] * m_vel[v]) >> 7)) bad_v = v;
            end
            check_output("cyc_ev_ready", 32'(ev_ready), 32'(m_ready));
            check_output("cyc_voice_active", 32'(voice_active), 32'(exp_act));
            checks++;
            if (bad_f >= 0) begin
               errors++;
               $display("[TB] FAIL cyc_freq[%0d]: got 0x%08h expected 0x%08h at %0t",
                        bad_f, frequencies[bad_f], m_freq[bad_f], $time);
            end
            checks++;
            if (bad_v >= 0) begin
               errors++;
               $display("[TB] FAIL cyc_volume[%0d]: got 0x%08h expected 0x%08h at %0t",
                        bad_v, voice_volumes[bad_v], 32'((m_level[bad_v] * m_vel[bad_v]) >> 7), $time);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      ev_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_ev_ready", 32'(ev_ready), 32'd0);
      check_output("rst_active", 32'(voice_active), 32'd0);
      check_output("rst_freq0", frequencies[0], 32'd450560);
      check_output("rst_vol0", voice_volumes[0], 32'd0);
      reset_n = 1'b1;
   endtask

   // Offer one event, then return at the first falling edge where its effect is visible
   task automatic apply_stimulus(bit on, int note, int vel);
      int waited;
      waited = 0;
      while (ev_ready !== 1'b1 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (ev_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL ev_ready_wait: got %b expected 1 after 10 cycles", ev_ready);
      end
      ev_valid    = 1'b1;
      ev_note_on  = on;
      ev_note     = 7'(note);
      ev_velocity = 7'(vel);
      @(negedge clk);
      ev_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_voice0_idle(input string name);
      int n;
      n = 0;
      while (voice_active[0] !== 1'b0 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check_output(name, 32'(voice_active[0]), 32'd0);
   endtask

   initial begin
      logic [31:0] ramp [$];
      logic [31:0] last;
      logic [31:0] exp_ramp [4];
      exp_ramp = '{32'h3F80, 32'h7F00, 32'hBE80, 32'hFDFF};

      for (int k = 0; k < 12; k++) begin
         base_tab[k] = $rtoi($floor(440.0 * 1024.0 * $pow(2.0, real'(k - 69) / 12.0) + 0.5));
      end
      check_output("model_base0", base_tab[0], 32'd8372);
      check_output("model_base8", base_tab[8], 32'd13290);
      check_output("model_base9", base_tab[9], 32'd14080);

      // Note 69 lands on voice 0 at 440 Hz
      do_reset();
      apply_stimulus(1'b1, 69, 127);
      check_output("a4_freq0", frequencies[0], 32'd450560);
      check_output("a4_active", 32'(voice_active), 32'h01);
      check_output("a4_ready", 32'(ev_ready), 32'd1);
      check_output("model_a4_freq0", m_freq[0], 32'd450560);

      // Attack ramp of note 60 at full velocity
      do_reset();
      apply_stimulus(1'b1, 60, 127);
      check_output("c4_freq0", frequencies[0], 32'd267904);
      check_output("model_c4_freq0", m_freq[0], 32'd267904);
      last = 32'd0;
      for (int i = 0; i < 40 && ramp.size() < 4; i++) begin
         if (voice_volumes[0] !== last) begin
            ramp.push_back(voice_volumes[0]);
            last = voice_volumes[0];
         end
         @(negedge clk);
      end
      check_output("ramp_steps", 32'(ramp.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("ramp[%0d]", i), (i < ramp.size()) ? ramp[i] : 32'd0, exp_ramp[i]);
      end
      repeat (ENV_DIV + 1) @(negedge clk);
      check_output("sustain_hold", voice_volumes[0], 32'hFDFF);

      // Note-off drops to zero on the next tick, pitch is kept
      apply_stimulus(1'b0, 60, 0);
      wait_voice0_idle("release_idle");
      check_output("release_vol0", voice_volumes[0], 32'd0);
      check_output("release_freq0", frequencies[0], 32'd267904);

      // Velocity-zero note-on releases the held voice and allocates nothing
      apply_stimulus(1'b1, 69, 127);
      apply_stimulus(1'b1, 69, 0);
      check_output("vel0_active", 32'(voice_active), 32'h01);
      check_output("vel0_freq0", frequencies[0], 32'd450560);
      wait_voice0_idle("vel0_idle");

      // Nine note-ons against eight voices
      do_reset();
      for (int n = 60; n <= 68; n++) begin
         apply_stimulus(1'b1, n, 100);
      end
      check_output("nine_active", 32'(voice_active), 32'hFF);
      check_output("nine_freq7", frequencies[7], 32'd401408);
`ifdef VOICE_STEAL_EN
      check_output("nine_freq0", frequencies[0], 32'd425280);
`else
      check_output("nine_freq0", frequencies[0], 32'd267904);
`endif

      // Random traffic with occasional mid-event resets
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ev_valid   = ($urandom_range(0, 2) != 0);
         ev_note_on = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) ev_note = 7'($urandom_range(0, 127));
         else ev_note = 7'(60 + $urandom_range(0, 9));
         if ($urandom_range(0, 5) == 0) ev_velocity = 7'd0;
         else ev_velocity = 7'($urandom_range(1, 127));
         if (c == 1500 || c == 2901) begin
            #2 reset_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
         end
      end
      ev_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
